// File: rtl/seg_ring_monitor_pkg.sv
// Shared types and helpers for the segment ring monitor and its transmitter model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_ring_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Segment bit positions on the 7-segment bus (bit 0 = segment a).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // One rotation step of the ring: {r2,r1,r0} -> {r1,r0,r2}.
    function automatic logic [2:0] rotl3(input logic [2:0] v);
        return {v[1:0], v[2]};
    endfunction

endpackage

// File: rtl/seg_ring_decode.sv
// Decodes the segment bus back to the 3-bit ring value and checks it is well formed.
// Latency: combinational.
// Backpressure: none.
module seg_ring_decode
    import seg_ring_monitor_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [2:0] ring_dec,
    output logic       well_formed
);

    logic fill;

    // Ring bits live on a, b, g; c mirrors b and d/e/f light whenever a or g is lit.
    always_comb begin
        ring_dec    = {seg_in[SEG_G], seg_in[SEG_B], seg_in[SEG_A]};
        fill        = seg_in[SEG_A] | seg_in[SEG_G];
        well_formed = (seg_in[SEG_C] == seg_in[SEG_B]) &&
                      (seg_in[SEG_D] == fill) &&
                      (seg_in[SEG_E] == fill) &&
                      (seg_in[SEG_F] == fill);
    end

endmodule

// File: rtl/seg_ring_monitor.sv
// Follows the rotating ring pattern on the segment bus, counts good rotations and errors.
// Latency: 1 cycle from a seg_valid sample to every output.
// Backpressure: none; accepts one sample per cycle, idle when seg_valid is low.
module seg_ring_monitor
    import seg_ring_monitor_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    input  logic             run,
    output logic [2:0]       ring_q,
    output logic             frame_ok,
    output logic             locked,
    output logic             err_flag,
    output logic [CNT_W-1:0] rot_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t           state_q, state_d;
    logic [2:0]       ring_d;
    logic             frame_ok_q, frame_ok_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       good_q, good_d;
    logic [2:0]       ring_r;

    logic [2:0] dec;
    logic       wf;
    logic       err_hit;
    logic       uniform;
    logic [3:0] good_inc;

    seg_ring_decode u_decode (
        .seg_in      (seg_in),
        .ring_dec    (dec),
        .well_formed (wf)
    );

    // Next-state logic: one decision per accepted sample; malformed and mismatch fold into a single error.
    always_comb begin
        state_d    = state_q;
        ring_d     = ring_r;
        frame_ok_d = frame_ok_q;
        err_flag_d = err_flag_q;
        rot_cnt_d  = rot_cnt_q;
        err_cnt_d  = err_cnt_q;
        good_d     = good_q;
        err_hit    = 1'b0;
        uniform    = (dec == 3'b000) || (dec == 3'b111);
        good_inc   = (good_q == 4'hF) ? good_q : good_q + 4'd1;

        if (seg_valid) begin
            frame_ok_d = wf;
            if (!wf) begin
                // Bad frame: value is untrustworthy, so keep the last accepted ring.
                err_hit = 1'b1;
                if (state_q != ST_IDLE) begin
                    good_d  = 4'd0;
                    state_d = ST_TRACK;
                end
            end else if (state_q == ST_IDLE) begin
                ring_d  = dec;
                state_d = ST_TRACK;
            end else if (!run) begin
                ring_d  = dec;
                good_d  = 4'd0;
                state_d = ST_TRACK;
            end else if (dec == rotl3(ring_r)) begin
                ring_d    = dec;
                rot_cnt_d = rot_cnt_q + CNT_W'(1);
                good_d    = good_inc;
                // A uniform ring proves nothing about rotation, so it never earns lock.
                if (state_q == ST_TRACK && !uniform && good_inc >= 4'(LOCK_N)) begin
                    state_d = ST_LOCKED;
                end
            end else begin
                // Sequence break: resync on the new value.
                err_hit = 1'b1;
                ring_d  = dec;
                good_d  = 4'd0;
                state_d = ST_TRACK;
            end
        end

        if (err_hit) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ring_r     <= 3'b000;
            frame_ok_q <= 1'b0;
            err_flag_q <= 1'b0;
            rot_cnt_q  <= '0;
            err_cnt_q  <= '0;
            good_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            ring_r     <= ring_d;
            frame_ok_q <= frame_ok_d;
            err_flag_q <= err_flag_d;
            rot_cnt_q  <= rot_cnt_d;
            err_cnt_q  <= err_cnt_d;
            good_q     <= good_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        ring_q   = ring_r;
        frame_ok = frame_ok_q;
        err_flag = err_flag_q;
        rot_cnt  = rot_cnt_q;
        err_cnt  = err_cnt_q;
        locked   = (state_q == ST_LOCKED);
    end

endmodule

// File: tb/tb_seg_ring_monitor.sv
// Bench for seg_ring_monitor: two instances (8-bit and 2-bit counters) on shared stimulus.
// Latency: outputs compared against a behavioural model on every falling edge.
// Backpressure: n/a.
module tb_seg_ring_monitor;
    import seg_ring_monitor_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'd0;
    logic       seg_valid = 1'b0;
    logic       run = 1'b0;

    logic [2:0] a_ring, b_ring;
    logic       a_ok, b_ok, a_lock, b_lock, a_flag, b_flag;
    logic [7:0] a_rot, a_err;
    logic [1:0] b_rot, b_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Behavioural model: mode 0 = not yet synced, 1 = following, 2 = locked.
    int       m_mode;
    logic [2:0] m_ring;
    bit       m_ok, m_flag;
    int       m_good, m_rots, m_errs;

    always #5 clk = ~clk;

    seg_ring_monitor #(.CNT_W(8), .LOCK_N(3)) u_dut_a (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_valid(seg_valid), .run(run),
        .ring_q(a_ring), .frame_ok(a_ok), .locked(a_lock), .err_flag(a_flag),
        .rot_cnt(a_rot), .err_cnt(a_err)
    );

    seg_ring_monitor #(.CNT_W(2), .LOCK_N(3)) u_dut_b (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_valid(seg_valid), .run(run),
        .ring_q(b_ring), .frame_ok(b_ok), .locked(b_lock), .err_flag(b_flag),
        .rot_cnt(b_rot), .err_cnt(b_err)
    );

    function automatic logic [6:0] enc(input logic [2:0] r);
        logic [6:0] s;
        s[0]   = r[0];
        s[1]   = r[1];
        s[2]   = r[1];
        s[6]   = r[2];
        s[5:3] = {3{r[0] | r[2]}};
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ring = 3'b000; m_ok = 0; m_flag = 0;
        m_good = 0; m_rots = 0; m_errs = 0;
    endtask

    task automatic model_apply(input bit r, input bit v, input bit ru, input logic [6:0] s);
        logic [2:0] d;
        bit         good_frame;
        if (r) begin
            model_reset();
            return;
        end
        if (!v) return;
        d = {s[6], s[1], s[0]};
        good_frame = (s[2] == s[1]) && (s[5:3] == {3{s[0] | s[6]}});
        m_ok = good_frame;
        if (!good_frame) begin
            m_errs++; m_flag = 1;
            if (m_mode != 0) begin m_good = 0; m_mode = 1; end
        end else if (m_mode == 0) begin
            m_ring = d; m_mode = 1;
        end else if (!ru) begin
            m_ring = d; m_good = 0; m_mode = 1;
        end else if (d == rotl3(m_ring)) begin
            m_ring = d; m_rots++; m_good++;
            if (m_mode == 1 && d != 3'b000 && d != 3'b111 && m_good >= 3) m_mode = 2;
        end else begin
            m_errs++; m_flag = 1; m_good = 0; m_mode = 1; m_ring = d;
        end
    endtask

    task automatic step(input bit r, input bit v, input bit ru, input logic [6:0] s);
        rst = r; seg_valid = v; run = ru; seg_in = s;
        @(posedge clk);
        #1;
        model_apply(r, v, ru, s);
    endtask

    // Every cycle: both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_ring", a_ring, m_ring);
            check("a_ok", a_ok, m_ok);
            check("a_lock", a_lock, m_mode == 2);
            check("a_flag", a_flag, m_flag);
            check("a_rot", a_rot, m_rots & 255);
            check("a_err", a_err, sat(m_errs, 8));
            check("b_ring", b_ring, m_ring);
            check("b_lock", b_lock, m_mode == 2);
            check("b_rot", b_rot, m_rots & 3);
            check("b_err", b_err, sat(m_errs, 2));
        end
    end

    initial begin
        model_reset();
        step(1, 0, 0, 7'd0);
        step(1, 0, 0, 7'd0);
        chk_en = 1'b1;
        check("rst_ring", a_ring, 3'b000);
        check("rst_lock", a_lock, 0);
        check("rst_ok", a_ok, 0);
        check("rst_flag", a_flag, 0);
        check("rst_rot", a_rot, 0);
        check("rst_err", a_err, 0);

        // Clean rotation: load 001, then 010, 100, 001.
        step(0, 1, 0, enc(3'b001));
        check("load_ring", a_ring, 3'b001);
        step(0, 1, 1, enc(3'b010));
        step(0, 1, 1, enc(3'b100));
        check("lock_not_yet", a_lock, 0);
        step(0, 1, 1, enc(3'b001));
        check("lock_rise", a_lock, 1);
        check("clean_rot", a_rot, 3);
        check("clean_err", a_err, 0);

        // Malformed (c != b) while locked; its decode also mismatches -> one error.
        step(0, 1, 1, enc(3'b001) ^ 7'b0000100);
        check("mal_ok", a_ok, 0);
        check("mal_err", a_err, 1);
        check("mal_flag", a_flag, 1);
        check("mal_lock", a_lock, 0);
        check("mal_ring", a_ring, 3'b001);

        // Sequence break: at 010 present 001, then 010 is good again.
        step(0, 1, 1, enc(3'b010));
        check("wrap_b_rot", b_rot, 0);
        step(0, 1, 1, enc(3'b001));
        check("brk_err", a_err, 2);
        check("brk_ring", a_ring, 3'b001);
        step(0, 1, 1, enc(3'b010));
        check("brk_resync_rot", a_rot, 5);

        // Relock, then load 110 mid-run and relock after three rotations.
        step(0, 1, 1, enc(3'b100));
        step(0, 1, 1, enc(3'b001));
        check("relock", a_lock, 1);
        step(0, 1, 0, enc(3'b110));
        check("ld_lock", a_lock, 0);
        check("ld_ring", a_ring, 3'b110);
        check("ld_err", a_err, 2);
        step(0, 1, 1, enc(3'b101));
        step(0, 1, 1, enc(3'b011));
        step(0, 1, 1, enc(3'b110));
        check("ld_relock", a_lock, 1);
        check("ld_rot", a_rot, 10);

        // Uniform: load 111, ten rotations of 111 never lock.
        step(0, 1, 0, enc(3'b111));
        for (int i = 0; i < 10; i++) step(0, 1, 1, enc(3'b111));
        check("uni_rot", a_rot, 20);
        check("uni_lock", a_lock, 0);
        check("uni_err", a_err, 2);

        // Idle cycles with garbage on the bus change nothing.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 7'b0101010);
        check("idle_rot", a_rot, 20);

        // Five errors: b saturates at 3, a keeps counting.
        step(0, 1, 1, 7'b0010001);
        for (int i = 0; i < 4; i++) step(0, 1, 1, enc(3'b101) ^ 7'b0000100);
        check("sat_b_err", b_err, 3);
        check("sat_a_err", a_err, 7);
        check("sat_b_flag", b_flag, 1);

        // Reset together with a valid sample.
        step(1, 1, 1, enc(3'b111));
        check("mid_rst_ring", a_ring, 3'b000);
        check("mid_rst_err", a_err, 0);
        check("mid_rst_rot", a_rot, 0);
        check("mid_rst_flag", a_flag, 0);

        // Malformed in IDLE stays unsynced; a good sample then syncs.
        step(0, 1, 1, 7'b0001000);
        check("idle_mal_err", a_err, 1);
        check("idle_mal_ring", a_ring, 3'b000);
        step(0, 1, 1, enc(3'b011));
        check("idle_sync_ring", a_ring, 3'b011);
        step(0, 1, 1, enc(3'b110));
        step(0, 0, 0, 7'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_ring_monitor.md
# seg_ring_monitor

Receive-side checker for the three-bit rotating segment pattern that the ring rotator drives onto the 7-segment bus. It samples the segment bus, decodes it back to the 3-bit ring state and checks that the bus is well formed. It follows the rotation sequence, counts good rotations and flags any step that breaks the sequence. It sits on the observation side of the display path, either in a loop-back test tile or next to the rotator as a self-check.

## Interface
- CNT_W, 8: width of the rotation and error counters, in bits.
- LOCK_N, 3: number of consecutive good rotations needed to enter LOCKED; legal range 1..15.
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- seg_in  in  7  sampled segment bus, bit 0 = segment a.
- seg_valid  in  1  sample strobe; seg_in is evaluated only in cycles where this is high.
- run  in  1  mode of the transmitter: 1 = rotate step expected, 0 = parallel load expected.
- ring_q  out  3  decoded ring state {r2,r1,r0}.
- frame_ok  out  1  last accepted sample was well formed.
- locked  out  1  high while the FSM is in LOCKED.
- err_flag  out  1  sticky error flag; cleared only by rst.
- rot_cnt  out  CNT_W  count of good rotations; wraps at 2^CNT_W.
- err_cnt  out  CNT_W  count of errors; saturates at all-ones.

## Operation
- **Decode:** r0 = seg_in[0], r1 = seg_in[1], r2 = seg_in[6].
- **Well-formed rule:** the sample is well formed iff both hold:
  - seg_in[2] == seg_in[1];
  - seg_in[3], seg_in[4] and seg_in[5] all equal (seg_in[0] | seg_in[6]).
- **Expected rotation:** exp = {prev[1:0], prev[2]}, where prev is the last accepted ring_q.
- **Uniform patterns:** 000 and 111 are uniform. A uniform pattern maps to itself under rotation.
- **Error sources:**
  - a malformed sample;
  - in TRACK or LOCKED with run=1, a decoded value that differs from exp.
- **FSM states:** IDLE, TRACK, LOCKED. Reset state is IDLE.
- **IDLE:**
  - A well-formed sample is captured into ring_q and the FSM moves to TRACK.
  - A malformed sample counts as an error and the FSM stays in IDLE.
- **TRACK:**
  - run=1, matching exp: rot_cnt+1 and the good-run counter +1. A non-uniform pattern whose good-run counter reaches LOCK_N moves the FSM to LOCKED.
  - run=1, mismatch: counts as an error, the good-run counter clears, and the new value is captured anyway (resync).
  - run=0: load. Capture the value, clear the good-run counter, stay in TRACK, no error.
- **LOCKED:**
  - A good rotation gives rot_cnt+1.
  - Any error moves the FSM to TRACK and clears the good-run counter; the value is captured.
  - A run=0 load moves the FSM to TRACK without an error.
- **Malformed sample in any state:** ring_q and prev keep their values; frame_ok=0; err_cnt+1; err_flag=1. In TRACK or LOCKED the good-run counter also clears; LOCKED falls back to TRACK.
- **Idle cycles:** when seg_valid=0, no state, output or counter changes.

## Timing
- **Reset values:** ring_q=000, frame_ok=0, locked=0, err_flag=0, rot_cnt=0, err_cnt=0, good-run counter=0, state=IDLE.
- **Latency:** all outputs are registered. A sample with seg_valid high in cycle N is reflected on every output after the clock edge that ends cycle N (1-cycle latency).
- **Throughput:** one sample per cycle; back-to-back seg_valid is supported.
- **Reset mid-operation:** rst high together with seg_valid discards the sample; all outputs take reset values at that edge.
- **Simultaneous events:** a malformed sample that also mismatches counts as one error (err_cnt+1, not +2).
- **Counter boundaries:**
  - rot_cnt wraps from all-ones to 0 with no flag.
  - err_cnt holds at all-ones, while err_flag stays 1.

## Structure
- **Shared package:** the state enum (IDLE/TRACK/LOCKED), the segment bit-index constants, and the rotate-left-by-one function. The same function is used by the transmitter model in the bench.
- **Sub-module seg_ring_decode:** combinational. Takes seg_in and produces the decoded value and a well-formed flag.
- **Top level:** the FSM and the counters.

## Test plan
- **Reset, then clean rotation:** rst, then a load of 001 (run=0), then rotating samples 010, 100, 001 with run=1 -> locked rises after the 3rd rotation; rot_cnt=3; err_cnt=0.
- **Malformed sample while LOCKED:** seg_in with seg[2]≠seg[1] -> frame_ok=0, err_cnt=1, err_flag=1, locked=0, ring_q unchanged.
- **Sequence break:** while tracking 010 with run=1, present 001 -> err_cnt+1; ring_q=001; the next sample 010 counts as a good rotation.
- **Load mid-run:** LOCKED, then run=0 with 110 -> state TRACK, ring_q=110, no error; after 3 rotations (101, 011, 110) locked=1 again.
- **Uniform pattern:** load 111, then 10 samples of 111 with run=1 -> rot_cnt=10, locked stays 0, no errors.
- **Boundaries:** CNT_W=2 -> rot_cnt wraps 3→0; 5 consecutive errors -> err_cnt holds at 3. rst asserted with seg_valid high -> all outputs return to reset values.
